pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central hazard and stall sequencer for the 5-stage pipeline. It drives the write-enable and flush controls of the PC, the IF/ID register and the ID/EX register, and inserts bubbles into EX/MEM. It resolves load-use hazards, taken-branch flushes, multi-cycle EX operations (mul/div) and data-memory stalls. It also keeps a saturating stall-cycle performance counter.

Parameters:
REG_ADDR_W, 5, register-address width
MC_LAT, 4, total cycles a multi-cycle op occupies EX (legal range >= 2)
CNT_W, 16, width of the stall performance counter

Ports:
clk  in  1  pipeline clock
reset  in  1  synchronous, active-high reset
id_rs1  in  REG_ADDR_W  source register 1 of the instruction in ID
id_rs2  in  REG_ADDR_W  source register 2 of the instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rd  in  REG_ADDR_W  destination register of the instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_branch_taken  in  1  EX resolved a taken branch or jump
ex_mc_start  in  1  first EX cycle of a multi-cycle op
mem_stall  in  1  data memory not ready; freeze the whole pipe
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID clear to NOP
id_ex_write  out  1  ID/EX load enable
id_ex_flush  out  1  ID/EX loads a bubble (all control bits 0)
ex_mem_bubble  out  1  EX/MEM loads a bubble
state  out  2  current FSM state (debug)
stall_count  out  CNT_W  cycles with pc_write==0, saturating

Behaviour:
- Reset is fixed: one clock; reset is synchronous and active-high.
- While reset=1:
  - pc_write=0, if_id_write=0, id_ex_write=0.
  - if_id_flush=1, id_ex_flush=1, ex_mem_bubble=1.
  - Next state RUN; cnt<=0; stall_count<=0.
- Control outputs are combinational from the registered state/cnt and the current inputs. This gives zero-latency hazard response.
- Default (no event): pc_write=1, if_id_write=1, id_ex_write=1; all flushes and bubble are 0.
- Encodings: RUN=2'b00, MC_BUSY=2'b01. cnt is a counter of width clog2(MC_LAT).
- Priority in RUN, highest first:
  1. mem_stall=1: all writes 0; no flush, no bubble; state and cnt hold.
  2. ex_branch_taken=1:
     - pc_write=1, if_id_write=1, id_ex_write=1, if_id_flush=1, id_ex_flush=1.
     - Stay in RUN.
     - A coincident load-use match or ex_mc_start is ignored.
  3. ex_mc_start=1:
     - pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_bubble=1.
     - cnt<=MC_LAT-2; next state MC_BUSY.
  4. Load-use:
     - Condition: ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
     - Response: pc_write=0, if_id_write=0, id_ex_write=1, id_ex_flush=1.
     - Stay in RUN. The stall lasts exactly one cycle because the bubble clears the match.
- MC_BUSY:
  - mem_stall=1: full freeze as above; cnt holds.
  - cnt!=0: same freeze+bubble outputs as the start cycle; cnt<=cnt-1.
  - cnt==0 (release cycle): default outputs; next state RUN.
  - ex_branch_taken, ex_mem_read and ex_mc_start are ignored in MC_BUSY.
  - Net effect without mem_stall: MC_LAT-1 frozen cycles, then release on cycle MC_LAT.
- stall_count: increments by 1 on each non-reset cycle with pc_write==0. It holds at 2^CNT_W-1.
- Reset mid-MC_BUSY: the next state is RUN with cnt=0. The in-flight op is abandoned, with no release cycle.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum (RUN, MC_BUSY);
  - the REG_ADDR_W default;
  - a typedef for the control-output bundle {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_bubble}.
- Sub-module load_use_detect: purely combinational comparator producing the load-use hit. It is reused by the forwarding-unit checks.

Test Plan:
1. Reset held 3 cycles, then released with all inputs 0 -> during reset writes=0 and flushes/bubble=1. After release pc_write=if_id_write=id_ex_write=1, state=0, stall_count=0.
2. ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> one cycle with pc_write=0, if_id_write=0, id_ex_flush=1, and stall_count=1. Repeating with ex_rd=0, or with id_use_rs2=0 -> no stall.
3. ex_branch_taken=1 together with the load-use match from test 2 -> if_id_flush=1, id_ex_flush=1, pc_write=1; stall_count unchanged.
4. MC_LAT=4, one-cycle ex_mc_start pulse -> pc_write=0 and ex_mem_bubble=1 for 3 consecutive cycles (state=1 on the last two). The 4th cycle has all writes=1, then state=0; stall_count +3.
5. MC_LAT=4, mem_stall=1 for 2 cycles while in MC_BUSY with cnt=1 -> all writes 0, no bubble, cnt held; 5 frozen cycles in total, then release; stall_count +5.
6. Reset asserted in MC_BUSY with cnt=1 -> next cycle state=0, cnt=0, stall_count=0. Separately, CNT_W=4 with 20 consecutive load-use stalls -> stall_count saturates at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: state encoding and control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MC_BUSY = 2'b01
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_bubble;
  } ctrl_t;

  // Free-running pipe: everything loads, nothing is squashed.
  localparam ctrl_t CTRL_DEFAULT = 6'b110100;
  // Reset: hold PC and registers, flush every stage to NOP.
  localparam ctrl_t CTRL_RESET   = 6'b001011;
  // Data-memory freeze: nothing moves, nothing is squashed.
  localparam ctrl_t CTRL_FREEZE  = 6'b000000;
  // Multi-cycle op in EX: front end frozen, bubbles drain into EX/MEM.
  localparam ctrl_t CTRL_MC      = 6'b000001;
  // Load-use: hold IF/ID and PC, push one bubble into ID/EX.
  localparam ctrl_t CTRL_LU      = 6'b000110;
  // Taken branch: fetch the target, squash the two wrong-path instructions.
  localparam ctrl_t CTRL_BRANCH  = 6'b111110;

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: flags an ID source register produced by a load still in EX.
// Latency: purely combinational.
// Backpressure: none; consumer decides how to stall.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_use_rs1_i,
  input  logic                  id_use_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_mem_read_i,
  output logic                  hit_o
);

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  always_comb begin
    hit_o = ex_mem_read_i && (ex_rd_i != '0) &&
            ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
             (id_use_rs2_i && (id_rs2_i == ex_rd_i)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer: PC, IF/ID, ID/EX enables and flushes, EX/MEM bubble, stall counter.
// Latency: controls are combinational from registered state and current inputs (zero-cycle response).
// Backpressure: mem_stall freezes the whole pipe and holds all sequencer state.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int MC_LAT     = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  ex_mc_start,
  input  logic                  mem_stall,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_write,
  output logic                  id_ex_flush,
  output logic                  ex_mem_bubble,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int CW = $clog2(MC_LAT);
  // The start cycle is already frozen, so the counter covers the remaining MC_LAT-2 frozen cycles.
  localparam logic [CW-1:0] CNT_LOAD = CW'(MC_LAT - 2);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  ctrl_t            ctrl;
  logic             lu_hit;

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lu (
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_use_rs1_i  (id_use_rs1),
    .id_use_rs2_i  (id_use_rs2),
    .ex_rd_i       (ex_rd),
    .ex_mem_read_i (ex_mem_read),
    .hit_o         (lu_hit)
  );

  // State, multi-cycle countdown and stall counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  // Next state: a memory stall holds everything; a branch outranks a multi-cycle start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!mem_stall) begin
      case (state_q)
        RUN: begin
          if (!ex_branch_taken && ex_mc_start) begin
            state_d = MC_BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
        MC_BUSY: begin
          if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
          else             state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Control outputs in priority order; MC_BUSY ignores branch, load and start inputs.
  always_comb begin
    ctrl = CTRL_DEFAULT;
    if (reset) begin
      ctrl = CTRL_RESET;
    end else if (mem_stall) begin
      ctrl = CTRL_FREEZE;
    end else begin
      case (state_q)
        RUN: begin
          if (ex_branch_taken)  ctrl = CTRL_BRANCH;
          else if (ex_mc_start) ctrl = CTRL_MC;
          else if (lu_hit)      ctrl = CTRL_LU;
        end
        MC_BUSY: begin
          if (cnt_q != '0) ctrl = CTRL_MC;
        end
        default: ctrl = CTRL_DEFAULT;
      endcase
    end
  end

  // Saturating count of cycles where the PC did not advance.
  always_comb begin
    stall_d = stall_q;
    if (!ctrl.pc_write && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
  end

  assign pc_write      = ctrl.pc_write;
  assign if_id_write   = ctrl.if_id_write;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_write   = ctrl.id_ex_write;
  assign id_ex_flush   = ctrl.id_ex_flush;
  assign ex_mem_bubble = ctrl.ex_mem_bubble;
  assign state         = state_q;
  assign stall_count   = stall_q;

endmodule
